// File: rtl/mpeg_stream_feeder.sv
// Buffers 32-bit compressed-stream words from the host loader in a word FIFO
// and serializes them MSB-first into a byte stream paced by decoder backpressure.
module mpeg_stream_feeder #(
    parameter int FIFO_AW = 4
) (
    input  logic               sys_clk,
    input  logic               RESET_N,
    input  logic [31:0]        word_data,
    input  logic               word_valid,
    output logic               word_ready,
    input  logic               flush,
    input  logic               busy,
    output logic [7:0]         stream_data,
    output logic               stream_valid,
    output logic [FIFO_AW:0]   fifo_level,
    output logic [31:0]        byte_count,
    output logic               idle
);

    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]       state;
    logic [31:0]      mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic [31:0]      shift;
    logic [1:0]       idx;

    logic fifo_empty;
    logic push;
    logic emit;
    logic last;
    logic pop;

    // Pointers carry one extra wrap bit, so the difference is the occupancy 0..DEPTH.
    assign fifo_level = wr_ptr - rd_ptr;
    assign fifo_empty = (fifo_level == '0);
    assign word_ready = ~fifo_level[FIFO_AW];
    assign idle       = (state == IDLE) && fifo_empty;

    assign push = word_valid && word_ready && !flush;
    assign emit = (state == SEND) && !busy;
    assign last = emit && (idx == 2'd3);
    assign pop  = !flush && !fifo_empty && ((state == IDLE) || last);

    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= word_data;
        end
    end

    always_ff @(posedge sys_clk or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // A pop overrides the shift/index update so the 4th byte and the next load share one edge.
    always_ff @(posedge sys_clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= IDLE;
            shift        <= '0;
            idx          <= '0;
            stream_data  <= '0;
            stream_valid <= 1'b0;
            byte_count   <= '0;
        end else if (flush) begin
            state        <= IDLE;
            stream_valid <= 1'b0;
        end else begin
            stream_valid <= emit;
            if (emit) begin
                stream_data <= shift[31:24];
                shift       <= shift << 8;
                idx         <= idx + 2'd1;
                byte_count  <= byte_count + 32'd1;
            end
            if (pop) begin
                shift <= mem[rd_ptr[FIFO_AW-1:0]];
                idx   <= '0;
                state <= SEND;
            end else if (last) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_mpeg_stream_feeder.sv
// Self-checking bench: queue-based model of the word FIFO and byte serializer,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mpeg_stream_feeder;

    logic        sys_clk = 1'b0;
    logic        RESET_N = 1'b0;
    logic [31:0] word_data = '0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic        flush = 1'b0;
    logic        busy = 1'b0;
    logic [7:0]  stream_data;
    logic        stream_valid;
    logic [4:0]  fifo_level;
    logic [31:0] byte_count;
    logic        idle;

    always #5 sys_clk = ~sys_clk;

    mpeg_stream_feeder #(.FIFO_AW(4)) dut (
        .sys_clk     (sys_clk),
        .RESET_N     (RESET_N),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .flush       (flush),
        .busy        (busy),
        .stream_data (stream_data),
        .stream_valid(stream_valid),
        .fifo_level  (fifo_level),
        .byte_count  (byte_count),
        .idle        (idle)
    );

    int checks = 0;
    int failures = 0;

    // Model: words waiting in the FIFO, and bytes still to send from the current word.
    logic [31:0] mq[$];
    logic [7:0]  cur[$];
    logic        m_valid;
    logic [7:0]  m_data;
    logic [31:0] m_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        cur.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_count = '0;
    endtask

    task automatic model_load();
        logic [31:0] w;
        w = mq.pop_front();
        cur.delete();
        cur.push_back(w[31:24]);
        cur.push_back(w[23:16]);
        cur.push_back(w[15:8]);
        cur.push_back(w[7:0]);
    endtask

    task automatic model_step();
        bit acc;
        bit had;
        if (flush) begin
            mq.delete();
            cur.delete();
            m_valid = 1'b0;
            return;
        end
        acc = word_valid && (mq.size() < 16);
        had = (mq.size() > 0);
        if (cur.size() == 0) begin
            m_valid = 1'b0;
            if (had) model_load();
        end else if (busy) begin
            m_valid = 1'b0;
        end else begin
            m_valid = 1'b1;
            m_data  = cur.pop_front();
            m_count = m_count + 32'd1;
            if (cur.size() == 0 && had) model_load();
        end
        if (acc) mq.push_back(word_data);
    endtask

    task automatic compare();
        chk("stream_valid", 32'(stream_valid), 32'(m_valid));
        chk("stream_data",  32'(stream_data),  32'(m_data));
        chk("fifo_level",   32'(fifo_level),   32'(mq.size()));
        chk("word_ready",   32'(word_ready),   32'(mq.size() < 16));
        chk("byte_count",   byte_count,        m_count);
        chk("idle",         32'(idle),         32'(cur.size() == 0 && mq.size() == 0));
    endtask

    task automatic cycle();
        @(posedge sys_clk);
        if (RESET_N) model_step();
        else model_reset();
        @(negedge sys_clk);
        compare();
    endtask

    task automatic do_reset();
        RESET_N    = 1'b0;
        word_valid = 1'b0;
        flush      = 1'b0;
        busy       = 1'b0;
        model_reset();
        cycle();
        cycle();
        RESET_N = 1'b1;
        chk("rst_word_ready", 32'(word_ready), 32'd1);
        chk("rst_idle",       32'(idle),       32'd1);
        chk("rst_fifo_level", 32'(fifo_level), 32'd0);
        chk("rst_byte_count", byte_count,      32'd0);
        chk("rst_valid",      32'(stream_valid), 32'd0);
    endtask

    initial begin
        int n;

        // Single word, no backpressure: bytes on edges E0+2..E0+5.
        do_reset();
        word_data  = 32'h000001B3;
        word_valid = 1'b1;
        cycle();
        word_valid = 1'b0;
        chk("lat_e0_valid", 32'(stream_valid), 32'd0);
        cycle();
        chk("lat_e1_valid", 32'(stream_valid), 32'd0);
        cycle();
        chk("b0_valid", 32'(stream_valid), 32'd1);
        chk("b0_data",  32'(stream_data),  32'h00);
        cycle();
        chk("b1_data",  32'(stream_data),  32'h00);
        cycle();
        chk("b2_data",  32'(stream_data),  32'h01);
        cycle();
        chk("b3_data",  32'(stream_data),  32'hB3);
        chk("b3_valid", 32'(stream_valid), 32'd1);
        cycle();
        chk("after_valid", 32'(stream_valid), 32'd0);
        chk("after_count", byte_count, 32'd4);
        chk("after_idle",  32'(idle), 32'd1);

        // Fill under backpressure: 17 accepted, 18th ignored.
        do_reset();
        busy = 1'b1;
        for (int i = 0; i < 18; i++) begin
            word_valid = 1'b1;
            word_data  = $urandom;
            cycle();
        end
        word_valid = 1'b0;
        chk("full_level", 32'(fifo_level), 32'd16);
        chk("full_ready", 32'(word_ready), 32'd0);
        busy = 1'b0;
        repeat (80) cycle();
        chk("full_drain_count", byte_count, 32'd68);
        chk("full_drain_idle",  32'(idle),  32'd1);

        // Two words with busy toggling every cycle.
        do_reset();
        busy = 1'b1;
        word_valid = 1'b1;
        word_data  = 32'h11223344;
        cycle();
        word_data  = 32'h55667788;
        cycle();
        word_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            busy = (i % 2 == 0) ? 1'b0 : 1'b1;
            cycle();
        end
        chk("toggle_count", byte_count, 32'd8);

        // Flush after two bytes with three words queued.
        do_reset();
        busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            word_valid = 1'b1;
            word_data  = $urandom;
            cycle();
        end
        word_valid = 1'b0;
        chk("pre_flush_level", 32'(fifo_level), 32'd3);
        busy = 1'b0;
        cycle();
        cycle();
        chk("pre_flush_count", byte_count, 32'd2);
        flush = 1'b1;
        word_valid = 1'b1;
        word_data = 32'hDEADBEEF;
        cycle();
        flush = 1'b0;
        word_valid = 1'b0;
        chk("flush_valid", 32'(stream_valid), 32'd0);
        chk("flush_level", 32'(fifo_level),   32'd0);
        chk("flush_idle",  32'(idle),         32'd1);
        chk("flush_count", byte_count,        32'd2);
        repeat (3) cycle();
        chk("post_flush_count", byte_count, 32'd2);

        // Asynchronous reset mid-word, then a fresh word.
        do_reset();
        word_valid = 1'b1;
        word_data  = 32'h01020304;
        cycle();
        word_data  = 32'h05060708;
        cycle();
        word_valid = 1'b0;
        cycle();
        cycle();
        @(posedge sys_clk);
        model_step();
        #2;
        RESET_N = 1'b0;
        model_reset();
        #1;
        chk("async_valid", 32'(stream_valid), 32'd0);
        chk("async_level", 32'(fifo_level),   32'd0);
        chk("async_count", byte_count,        32'd0);
        @(negedge sys_clk);
        compare();
        cycle();
        RESET_N = 1'b1;
        cycle();
        chk("post_rst_silent", 32'(stream_valid), 32'd0);
        word_valid = 1'b1;
        word_data  = 32'hAABBCCDD;
        cycle();
        word_valid = 1'b0;
        cycle();
        cycle();
        chk("rw_b0", 32'(stream_data), 32'hAA);
        cycle();
        chk("rw_b1", 32'(stream_data), 32'hBB);
        cycle();
        chk("rw_b2", 32'(stream_data), 32'hCC);
        cycle();
        chk("rw_b3", 32'(stream_data), 32'hDD);
        chk("rw_b3_valid", 32'(stream_valid), 32'd1);

        // Full-rate writes: one byte per cycle, no gap at word boundaries.
        do_reset();
        n = 0;
        word_valid = 1'b1;
        for (int i = 0; i < 42; i++) begin
            word_data = $urandom;
            cycle();
            if (stream_valid) n++;
        end
        word_valid = 1'b0;
        chk("rate_bytes", 32'(n), 32'd40);
        chk("rate_count", byte_count, 32'd40);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            word_valid = ($urandom_range(0, 2) != 0);
            word_data  = $urandom;
            busy       = ($urandom_range(0, 3) == 0);
            flush      = ($urandom_range(0, 149) == 0);
            cycle();
        end
        word_valid = 1'b0;
        busy = 1'b0;
        flush = 1'b0;
        repeat (80) cycle();
        chk("rand_drain_idle", 32'(idle), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mpeg_stream_feeder.md
MPEG_STREAM_FEEDER -- requirements
Module: mpeg_stream_feeder

Interface
REQ-001 SHALL have parameter FIFO_AW, default 4, meaning log2 of the word FIFO depth (depth = 2^FIFO_AW = 16 words).
REQ-002 SHALL have port sys_clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port RESET_N, input, 1, reset; asynchronous assert, active-low.
REQ-004 SHALL have port word_data, input, 32, compressed-stream word from the host loader, first byte in [31:24].
REQ-005 SHALL have port word_valid, input, 1, word_data is valid this cycle.
REQ-006 SHALL have port word_ready, output, 1, FIFO can accept a word this cycle.
REQ-007 SHALL have port flush, input, 1, single-cycle request to discard all buffered data (seek/restart).
REQ-008 SHALL have port busy, input, 1, decoder backpressure; high means no byte may be presented.
REQ-009 SHALL have port stream_data, output, 8, byte to the decoder.
REQ-010 SHALL have port stream_valid, output, 1, stream_data is valid; one-cycle pulse per byte.
REQ-011 SHALL have port fifo_level, output, FIFO_AW+1, words currently held in the FIFO (0..16).
REQ-012 SHALL have port byte_count, output, 32, total bytes delivered since reset.
REQ-013 SHALL have port idle, output, 1, no buffered or in-flight data.

Function
REQ-014 SHALL write word_data into the FIFO on any edge where word_valid=1 and word_ready=1; word_valid with word_ready=0 SHALL have no effect.
REQ-015 SHALL drive word_ready = (fifo_level < 2^FIFO_AW), derived from registered state only.
REQ-016 SHALL, on a simultaneous FIFO push and pop, leave fifo_level unchanged and preserve word order.
REQ-017 SHALL implement serializer states IDLE and SEND, plus a 32-bit shift register and a 2-bit byte index.
REQ-018 IDLE: on an edge with fifo_level>0, SHALL pop the head word into the shift register, clear the byte index, and enter SEND.
REQ-019 SEND: on each edge with busy=0, SHALL register stream_data=shift[31:24], stream_valid=1, shift left by 8, and increment the byte index.
REQ-020 SEND: on an edge with busy=1, SHALL register stream_valid=0 and hold stream_data, the shift register, and the index.
REQ-021 SHALL, when the 4th byte is emitted, pop the next word in the same edge if fifo_level>0 (no bubble), else return to IDLE.
REQ-022 Latency: a word accepted at edge E0 with busy=0 throughout SHALL produce its first byte with stream_valid high in the cycle following edge E0+2; its bytes follow on consecutive cycles.
REQ-023 SHALL increment byte_count by 1 on every edge that registers stream_valid=1, wrapping from 0xFFFFFFFF to 0.
REQ-024 flush SHALL take priority over all else on its edge: FIFO emptied, fifo_level=0, state=IDLE, stream_valid=0, any same-cycle write discarded; byte_count is not cleared.
REQ-025 SHALL drive idle=1 iff state=IDLE and fifo_level=0.
REQ-026 SHALL never emit a byte twice nor skip a byte under any busy pattern.

Reset
REQ-027 While RESET_N=0, SHALL immediately clear the FIFO pointers, state=IDLE, shift register, index, stream_data=0, stream_valid=0, fifo_level=0, byte_count=0; word_ready=1 and idle=1.
REQ-028 Reset assertion mid-word SHALL drop all buffered data; no byte SHALL be emitted until new words are written after release.

Verification
REQ-029 Scenario: busy=0, write 0x000001B3 -> stream bytes 00,00,01,B3 on 4 consecutive cycles, first in the cycle after E0+2; byte_count=4; idle=1 afterwards.
REQ-030 Scenario: busy=1 held, 18 back-to-back writes -> 17 accepted (1 in the shift register, 16 in the FIFO), fifo_level=16, word_ready=0, 18th ignored.
REQ-031 Scenario: two words written, busy toggled 1/0 every cycle -> stream_valid only on busy-low edges; 8 bytes in order, no duplicates; byte_count=8.
REQ-032 Scenario: flush asserted after 2 bytes of a word with 3 words queued -> no further stream_valid, fifo_level=0 and idle=1 the next cycle, byte_count=2.
REQ-033 Scenario: RESET_N dropped asynchronously mid-SEND -> stream_valid=0 and fifo_level=0 without waiting for a clock edge; after release, new word 0xAABBCCDD delivers AA,BB,CC,DD.
REQ-034 Scenario: continuous writes at full rate with busy=0 -> one byte per cycle sustained, with no bubble at word boundaries.
